// File: rtl/column_select_encoder.sv
// Connect4 column selector: debounced left/right/drop buttons drive a one-hot
// cursor; a drop hands the cursor column to the game logic via valid/ready.
module column_select_encoder #(
  parameter int NUM_COLS        = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int START_COL       = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_drop,
  input  logic [NUM_COLS-1:0] column_full,
  input  logic                drop_ready,
  output logic [NUM_COLS-1:0] cursor_col,
  output logic [NUM_COLS-1:0] drop_column,
  output logic                drop_valid,
  output logic                drop_reject,
  output logic                board_full
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_COLS);
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DROP  = 2;
  localparam logic [NUM_COLS-1:0] ONE          = {{(NUM_COLS-1){1'b0}}, 1'b1};
  localparam logic [NUM_COLS-1:0] START_ONEHOT = ONE << START_COL;

  typedef enum logic {IDLE, PENDING} state_t;

  logic [2:0] raw;
  logic [2:0] pulse;

  assign raw = {btn_drop, btn_right, btn_left};

  // One synchroniser / debouncer / edge detector per button.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1;
      logic             sync2;
      logic             deb;
      logic             deb_d;
      logic             edge_pulse;
      logic [CNT_W-1:0] cnt;

      // Synchronise, debounce (flip after DEBOUNCE_CYCLES differing samples), detect rising edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1      <= 1'b0;
          sync2      <= 1'b0;
          deb        <= 1'b0;
          deb_d      <= 1'b0;
          edge_pulse <= 1'b0;
          cnt        <= '0;
        end else begin
          sync1      <= raw[gi];
          sync2      <= sync1;
          deb_d      <= deb;
          edge_pulse <= deb & ~deb_d;
          if (sync2 == deb) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= ~deb;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign pulse[gi] = edge_pulse;
    end
  endgenerate

  state_t              state;
  logic [IDX_W-1:0]    cur_idx;
  logic [IDX_W-1:0]    right_idx;
  logic [IDX_W-1:0]    left_idx;
  int                  right_tmp;
  int                  left_tmp;
  logic [NUM_COLS-1:0] right_next;
  logic [NUM_COLS-1:0] left_next;

  // Nearest free column above/below the cursor (wrapping), excluding the cursor itself.
  // Scanning from the farthest offset down lets the nearest free column win.
  always_comb begin
    cur_idx    = '0;
    right_idx  = '0;
    left_idx   = '0;
    right_tmp  = 0;
    left_tmp   = 0;
    right_next = cursor_col;
    left_next  = cursor_col;
    for (int k = 0; k < NUM_COLS; k++) begin
      if (cursor_col[k]) cur_idx = IDX_W'(k);
    end
    for (int k = NUM_COLS - 1; k >= 1; k--) begin
      right_tmp = int'(cur_idx) + k;
      if (right_tmp >= NUM_COLS) right_tmp = right_tmp - NUM_COLS;
      left_tmp = int'(cur_idx) - k;
      if (left_tmp < 0) left_tmp = left_tmp + NUM_COLS;
      right_idx = IDX_W'(right_tmp);
      left_idx  = IDX_W'(left_tmp);
      if (!column_full[right_idx]) right_next = ONE << right_idx;
      if (!column_full[left_idx])  left_next  = ONE << left_idx;
    end
  end

  // Cursor / drop handshake FSM; drop wins over moves, opposing moves cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cursor_col  <= START_ONEHOT;
      drop_column <= '0;
      drop_valid  <= 1'b0;
      drop_reject <= 1'b0;
      board_full  <= 1'b0;
    end else begin
      board_full  <= &column_full;
      drop_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (pulse[BTN_DROP]) begin
            if ((column_full & cursor_col) == '0) begin
              state       <= PENDING;
              drop_column <= cursor_col;
              drop_valid  <= 1'b1;
            end else begin
              drop_reject <= 1'b1;
            end
          end else if (pulse[BTN_RIGHT] && !pulse[BTN_LEFT]) begin
            cursor_col <= right_next;
          end else if (pulse[BTN_LEFT] && !pulse[BTN_RIGHT]) begin
            cursor_col <= left_next;
          end
        end
        PENDING: begin
          if (drop_ready) begin
            state       <= IDLE;
            drop_valid  <= 1'b0;
            drop_column <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
